// File: rtl/sample_packer.sv
// sample_packer: serial-to-parallel frame packer feeding adder_tree.
// Optional frame counter: define SAMPLE_PACKER_FRAME_CNT_EN for o_frame_cnt.
module sample_packer #(
    parameter int NUM_INPUTS = 16,
    parameter int DWIDTH     = 14,
    parameter int CWIDTH     = $clog2(NUM_INPUTS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DWIDTH-1:0]            i_dat,
    input  logic                         i_dat_valid,
    input  logic                         i_last,
    output logic [NUM_INPUTS*DWIDTH-1:0] o_dat_vector,
    output logic                         o_dat_valid,
    output logic [CWIDTH-1:0]            o_count,
    output logic [CWIDTH-1:0]            o_fill
`ifdef SAMPLE_PACKER_FRAME_CNT_EN
    ,
    output logic [15:0]                  o_frame_cnt
`endif
);

    localparam int VW = NUM_INPUTS * DWIDTH;
    localparam logic [CWIDTH-1:0] LAST_IDX = CWIDTH'(NUM_INPUTS - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    state_e            state_q, state_d;
    logic [CWIDTH-1:0] idx_q, idx_d;
    logic [VW-1:0]     asm_q, asm_d;
    logic [VW-1:0]     vec_q, vec_d;
    logic              valid_q, valid_d;
    logic [CWIDTH-1:0] count_q, count_d;
    logic [VW-1:0]     merged;
    logic              emit;

    // Register state, assembly buffer and the presented frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            asm_q   <= '0;
            vec_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Merge the incoming sample, decide on emit, and compute next state.
    always_comb begin
        merged = asm_q;
        for (int ii = 0; ii < NUM_INPUTS; ii++) begin
            if (i_dat_valid && (idx_q == CWIDTH'(ii))) begin
                merged[DWIDTH*ii +: DWIDTH] = i_dat;
            end
        end

        // A bare i_last only closes a frame that already holds samples.
        if (i_dat_valid) begin
            emit = i_last || (idx_q == LAST_IDX);
        end else begin
            emit = i_last && (state_q == FILL);
        end

        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        vec_d   = vec_q;
        valid_d = 1'b0;
        count_d = count_q;

        if (emit) begin
            vec_d   = merged;
            valid_d = 1'b1;
            count_d = idx_q + {{(CWIDTH-1){1'b0}}, i_dat_valid};
            asm_d   = '0;
            idx_d   = '0;
            state_d = IDLE;
        end else if (i_dat_valid) begin
            asm_d   = merged;
            idx_d   = idx_q + 1'b1;
            state_d = FILL;
        end
    end

`ifdef SAMPLE_PACKER_FRAME_CNT_EN
    logic [15:0] fcnt_q;

    // Count emitted frames; bumps on the same edge that raises o_dat_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q <= '0;
        end else if (emit) begin
            fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign o_frame_cnt = fcnt_q;
`endif

    assign o_dat_vector = vec_q;
    assign o_dat_valid  = valid_q;
    assign o_count      = count_q;
    assign o_fill       = idx_q;

endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: directed vectors for sample_packer.
// Table-driven cycles plus hand-written multi-cycle sequences.
module tb_sample_packer;

    localparam int N  = 16;
    localparam int DW = 14;
    localparam int CW = $clog2(N + 1);
    localparam int VW = N * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] i_dat;
    logic          i_dat_valid;
    logic          i_last;
    logic [VW-1:0] o_dat_vector;
    logic          o_dat_valid;
    logic [CW-1:0] o_count;
    logic [CW-1:0] o_fill;
`ifdef SAMPLE_PACKER_FRAME_CNT_EN
    logic [15:0]   o_frame_cnt;
`endif

    int total = 0;
    int bad   = 0;

    sample_packer #(
        .NUM_INPUTS(N),
        .DWIDTH    (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_dat       (i_dat),
        .i_dat_valid (i_dat_valid),
        .i_last      (i_last),
        .o_dat_vector(o_dat_vector),
        .o_dat_valid (o_dat_valid),
        .o_count     (o_count),
        .o_fill      (o_fill)
`ifdef SAMPLE_PACKER_FRAME_CNT_EN
        ,
        .o_frame_cnt (o_frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic          l;
        logic [DW-1:0] d;
        logic          ev;
        logic [CW-1:0] ec;
        logic [CW-1:0] ef;
        logic          cv;
        logic [VW-1:0] evec;
    } row_t;

    row_t tbl[$];

    task automatic add(input logic v, input logic l, input logic [DW-1:0] d,
                       input logic ev, input int ec, input int ef,
                       input logic cv, input logic [VW-1:0] evec);
        row_t r;
        r.v = v; r.l = l; r.d = d; r.ev = ev;
        r.ec = CW'(ec); r.ef = CW'(ef); r.cv = cv; r.evec = evec;
        tbl.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [VW-1:0] act,
                           input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic l, input logic [DW-1:0] d);
        i_dat_valid = v;
        i_last      = l;
        i_dat       = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [VW-1:0] vec5;
        logic [VW-1:0] vec3;
        logic [VW-1:0] exp;
        logic [DW-1:0] w;
        int            sum;

        vec5 = '0;
        for (int ii = 0; ii < 5; ii++) vec5[DW*ii +: DW] = 14'h3FFF;
        vec3 = '0;
        vec3[DW*0 +: DW] = 14'h011;
        vec3[DW*1 +: DW] = 14'h022;
        vec3[DW*2 +: DW] = 14'h033;

        // partial frame closed with the sample
        for (int k = 1; k <= 4; k++) add(1, 0, 14'h3FFF, 0, 16, k, 0, '0);
        add(1, 1, 14'h3FFF, 1, 5, 0, 1, vec5);
        // partial frame closed by a bare i_last after a gap
        add(1, 0, 14'h011, 0, 5, 1, 1, vec5);
        add(1, 0, 14'h022, 0, 5, 2, 0, '0);
        add(1, 0, 14'h033, 0, 5, 3, 0, '0);
        add(0, 0, 14'h000, 0, 5, 3, 0, '0);
        add(0, 0, 14'h000, 0, 5, 3, 0, '0);
        add(0, 1, 14'h000, 1, 3, 0, 1, vec3);
        // bare i_last with empty assembly is ignored
        for (int k = 0; k < 10; k++) add(0, 1, 14'h000, 0, 3, 0, 1, vec3);

        rst = 1'b1;
        i_dat = '0;
        i_dat_valid = 1'b0;
        i_last = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(o_dat_valid), 0);
        chk("rst_count", 32'(o_count), 0);
        chk("rst_fill", 32'(o_fill), 0);
        chk_vec("rst_vec", o_dat_vector, '0);
`ifdef SAMPLE_PACKER_FRAME_CNT_EN
        chk("rst_fcnt", 32'(o_frame_cnt), 0);
`endif
        rst = 1'b0;

        // full frame 1..16
        for (int k = 1; k <= 16; k++) begin
            w = DW'(k);
            step(1, 0, w);
            chk("t1_valid", 32'(o_dat_valid), (k == 16) ? 1 : 0);
        end
        exp = '0;
        for (int ii = 0; ii < N; ii++) exp[DW*ii +: DW] = DW'(ii + 1);
        chk_vec("t1_vec", o_dat_vector, exp);
        chk("t1_count", 32'(o_count), 16);
        sum = 0;
        for (int ii = 0; ii < N; ii++) sum += int'(o_dat_vector[DW*ii +: DW]);
        chk("t1_sum", 32'(sum), 32'h88);
        step(0, 0, '0);
        chk("t1_pulse_end", 32'(o_dat_valid), 0);
        chk_vec("t1_hold", o_dat_vector, exp);

        foreach (tbl[r]) begin
            step(tbl[r].v, tbl[r].l, tbl[r].d);
            chk($sformatf("row%0d_valid", r), 32'(o_dat_valid), 32'(tbl[r].ev));
            chk($sformatf("row%0d_count", r), 32'(o_count), 32'(tbl[r].ec));
            chk($sformatf("row%0d_fill", r), 32'(o_fill), 32'(tbl[r].ef));
            if (tbl[r].cv) chk_vec($sformatf("row%0d_vec", r), o_dat_vector, tbl[r].evec);
        end

        // 32 back-to-back samples, value = index
        for (int k = 0; k < 32; k++) begin
            w = DW'(k);
            step(1, 0, w);
            chk($sformatf("t4_valid%0d", k), 32'(o_dat_valid),
                (k == 15 || k == 31) ? 1 : 0);
            if (k == 15 || k == 31) begin
                exp = '0;
                for (int ii = 0; ii < N; ii++) exp[DW*ii +: DW] = DW'(k - 15 + ii);
                chk_vec($sformatf("t4_vec%0d", k), o_dat_vector, exp);
                chk("t4_count", 32'(o_count), 16);
            end
        end

        // reset mid-frame discards the partial frame
        for (int k = 0; k < 7; k++) begin
            step(1, 0, 14'h055);
            chk("t5_nopulse", 32'(o_dat_valid), 0);
        end
        chk("t5_fill7", 32'(o_fill), 7);
        rst = 1'b1;
        step(0, 0, '0);
        rst = 1'b0;
        chk("t5_rst_fill", 32'(o_fill), 0);
        chk("t5_rst_valid", 32'(o_dat_valid), 0);
        chk_vec("t5_rst_vec", o_dat_vector, '0);
        for (int k = 0; k < 16; k++) begin
            step(1, 0, 14'h001);
            chk("t5_valid", 32'(o_dat_valid), (k == 15) ? 1 : 0);
        end
        exp = '0;
        for (int ii = 0; ii < N; ii++) exp[DW*ii +: DW] = 14'h001;
        chk_vec("t5_vec", o_dat_vector, exp);
        chk("t5_count", 32'(o_count), 16);

        // single-sample frames on consecutive cycles
        for (int k = 0; k < 3; k++) begin
            w = DW'(14'h100 + k);
            step(1, 1, w);
            exp = '0;
            exp[DW-1:0] = w;
            chk("t6_valid", 32'(o_dat_valid), 1);
            chk("t6_count", 32'(o_count), 1);
            chk_vec("t6_vec", o_dat_vector, exp);
        end
        step(0, 0, '0);
        chk("t6_end", 32'(o_dat_valid), 0);

`ifdef SAMPLE_PACKER_FRAME_CNT_EN
        rst = 1'b1;
        step(0, 0, '0);
        rst = 1'b0;
        for (int k = 0; k < 65534; k++) step(1, 1, 14'h001);
        chk("fc_pre", 32'(o_frame_cnt), 32'hFFFE);
        step(1, 1, 14'h001);
        chk("fc_v0", 32'(o_dat_valid), 1);
        chk("fc_0", 32'(o_frame_cnt), 32'hFFFF);
        step(1, 1, 14'h001);
        chk("fc_1", 32'(o_frame_cnt), 32'h0000);
        step(1, 1, 14'h001);
        chk("fc_2", 32'(o_frame_cnt), 32'h0001);
        step(0, 0, '0);
        chk("fc_hold", 32'(o_frame_cnt), 32'h0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
